// File: rtl/cpu_defs.sv
// Shared CPU type definitions used by the fetch and issue stages.
package cpu_defs;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IFQ_DEPTH = 8;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] vaddr;
    logic [31:0]     instr;
    logic            iaddr_ex;
  } fetch_entry_t;

  typedef logic [1:0] fetch_ack_t;

  // Legal push patterns are 00, 01 and 11; 10 pushes nothing.
  function automatic logic [1:0] push_count(input logic [1:0] in_valid);
    case (in_valid)
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-issue queue bus: the fetch/issue side is master, the queue is slave.
interface instr_fetch_queue_if import cpu_defs::*; #(
  parameter int unsigned DEPTH = IFQ_DEPTH
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                    flush;
  logic [1:0]              in_valid;
  fetch_entry_t [1:0]      in_entry;
  logic                    in_ready;
  fetch_entry_t [1:0]      fetch_entry;
  fetch_ack_t              fetch_ack;
  logic [CNT_W-1:0]        count;

  modport master (
    output flush, in_valid, in_entry, fetch_ack,
    input  in_ready, fetch_entry, count
  );

  modport slave (
    input  flush, in_valid, in_entry, fetch_ack,
    output in_ready, fetch_entry, count
  );

endinterface

// File: rtl/instr_fetch_queue_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the fetch queue, with pop clamp and flush.
module fifo_ptr_ctrl import cpu_defs::*; #(
  parameter  int unsigned DEPTH = IFQ_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [1:0]       push_i,
  input  fetch_ack_t       ack_i,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic [CNT_W-1:0] count_o,
  output logic             in_ready_o,
  output logic [1:0]       wr_en_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       n_push, n_pop;
  logic             ready;

  always_comb begin
    ready   = (count_q <= CNT_W'(DEPTH - 2));
    n_push  = '0;
    wr_en_o = '0;
    if (ready && !flush_i) begin
      n_push  = push_count(push_i);
      wr_en_o = (n_push == 2'd2) ? 2'b11 : (n_push == 2'd1) ? 2'b01 : 2'b00;
    end
    // An over-ack can only happen when count < ack <= 3, so count fits in 2 bits.
    n_pop = (CNT_W'(ack_i) > count_q) ? count_q[1:0] : ack_i;

    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (CNT_W'(ack_i) <= count_q)
        else $warning("fetch_ack %0d exceeds occupancy %0d, clamped", ack_i, count_q);
      assert (push_i != 2'b10)
        else $warning("in_valid=2'b10 is illegal, treated as no push");
    end
  end

  assign head_o     = head_q;
  assign tail_o     = tail_q;
  assign count_o    = count_q;
  assign in_ready_o = ready;

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular instruction buffer between fetch and dual-issue decode; storage and output view.
module instr_fetch_queue import cpu_defs::*; #(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_queue_if.slave q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   head, tail, head_nx;
  logic [CNT_W-1:0]   count;
  logic [1:0]         wr_en;
  logic               ready;
  fetch_entry_t       mem [DEPTH];
  fetch_entry_t [1:0] out_entry;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (q.flush),
    .push_i     (q.in_valid),
    .ack_i      (q.fetch_ack),
    .head_o     (head),
    .tail_o     (tail),
    .count_o    (count),
    .in_ready_o (ready),
    .wr_en_o    (wr_en)
  );

  always_ff @(posedge clk) begin
    if (wr_en[0]) mem[tail] <= q.in_entry[0];
    if (wr_en[1]) mem[tail + PTR_W'(1)] <= q.in_entry[1];
  end

  assign head_nx = head + PTR_W'(1);

  always_comb begin
    out_entry = '0;
    if (count != '0) begin
      out_entry[0]       = mem[head];
      out_entry[0].valid = 1'b1;
    end
    if (count > CNT_W'(1)) begin
      out_entry[1]       = mem[head_nx];
      out_entry[1].valid = 1'b1;
    end
  end

  assign q.fetch_entry = out_entry;
  assign q.in_ready    = ready;
  assign q.count       = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed table-driven bench for instr_fetch_queue plus async-reset and reset-state sequences.
module tb_instr_fetch_queue;
  import cpu_defs::*;

  logic clk;
  logic rst;

  instr_fetch_queue_if #(.DEPTH(8)) q_if ();

  instr_fetch_queue #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [1:0]  iv;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  ack;
    logic [3:0]  cnt;
    logic        rdy;
    logic        v0;
    logic [31:0] e0;
    logic        v1;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic fetch_entry_t mk(input logic v, input logic [31:0] i);
    fetch_entry_t e;
    e = '0;
    if (v) begin
      e.valid    = 1'b1;
      e.vaddr    = i << 2;
      e.instr    = i;
      e.iaddr_ex = i[0];
    end
    return e;
  endfunction

  function automatic vec_t V(input logic fl, input logic [1:0] iv, input logic [31:0] i0,
                             input logic [31:0] i1, input logic [1:0] ack, input logic [3:0] cnt,
                             input logic rdy, input logic v0, input logic [31:0] e0,
                             input logic v1, input logic [31:0] e1);
    vec_t r;
    r.flush = fl; r.iv = iv; r.i0 = i0; r.i1 = i1; r.ack = ack;
    r.cnt = cnt; r.rdy = rdy; r.v0 = v0; r.e0 = e0; r.v1 = v1; r.e1 = e1;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] cnt, input logic rdy,
                       input logic v0, input logic [31:0] e0, input logic v1, input logic [31:0] e1);
    fetch_entry_t x0, x1;
    x0 = mk(v0, e0);
    x1 = mk(v1, e1);
    nvec++;
    if (q_if.count !== cnt || q_if.in_ready !== rdy ||
        q_if.fetch_entry[0] !== x0 || q_if.fetch_entry[1] !== x1) begin
      nbad++;
      $display("FAIL %s: count=%0d exp %0d ready=%0b exp %0b e0=%h exp %h e1=%h exp %h",
               name, q_if.count, cnt, q_if.in_ready, rdy,
               q_if.fetch_entry[0], x0, q_if.fetch_entry[1], x1);
    end
  endtask

  task automatic drive(input logic fl, input logic [1:0] iv, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [1:0] ack);
    q_if.flush       = fl;
    q_if.in_valid    = iv;
    q_if.in_entry[0] = mk(1'b1, i0);
    q_if.in_entry[1] = mk(1'b1, i1);
    q_if.fetch_ack   = ack;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // fill to full, overflow dropped, drain in pairs
    vecs.push_back(V(0, 2'b11,  1,  2, 0, 2, 1, 1,  1, 1,  2));
    vecs.push_back(V(0, 2'b11,  3,  4, 0, 4, 1, 1,  1, 1,  2));
    vecs.push_back(V(0, 2'b11,  5,  6, 0, 6, 1, 1,  1, 1,  2));
    vecs.push_back(V(0, 2'b11,  7,  8, 0, 8, 0, 1,  1, 1,  2));
    vecs.push_back(V(0, 2'b11,  9, 10, 0, 8, 0, 1,  1, 1,  2));
    vecs.push_back(V(0, 2'b00,  0,  0, 2, 6, 1, 1,  3, 1,  4));
    vecs.push_back(V(0, 2'b00,  0,  0, 2, 4, 1, 1,  5, 1,  6));
    vecs.push_back(V(0, 2'b00,  0,  0, 2, 2, 1, 1,  7, 1,  8));
    vecs.push_back(V(0, 2'b00,  0,  0, 2, 0, 1, 0,  0, 0,  0));
    // walk head to 6 with count 2, then push+pop straddling the wrap
    vecs.push_back(V(0, 2'b11, 11, 12, 0, 2, 1, 1, 11, 1, 12));
    vecs.push_back(V(0, 2'b11, 13, 14, 2, 2, 1, 1, 13, 1, 14));
    vecs.push_back(V(0, 2'b11, 15, 16, 2, 2, 1, 1, 15, 1, 16));
    vecs.push_back(V(0, 2'b11, 17, 18, 2, 2, 1, 1, 17, 1, 18));
    vecs.push_back(V(0, 2'b11, 19, 20, 2, 2, 1, 1, 19, 1, 20));
    // partial consumption
    vecs.push_back(V(0, 2'b01, 21,  0, 0, 3, 1, 1, 19, 1, 20));
    vecs.push_back(V(0, 2'b00,  0,  0, 1, 2, 1, 1, 20, 1, 21));
    vecs.push_back(V(0, 2'b00,  0,  0, 2, 0, 1, 0,  0, 0,  0));
    // over-ack clamp, then confirm no underflow
    vecs.push_back(V(0, 2'b01, 22,  0, 0, 1, 1, 1, 22, 0,  0));
    vecs.push_back(V(0, 2'b00,  0,  0, 2, 0, 1, 0,  0, 0,  0));
    vecs.push_back(V(0, 2'b11, 23, 24, 0, 2, 1, 1, 23, 1, 24));
    // illegal in_valid=10 is no push
    vecs.push_back(V(0, 2'b10, 25, 26, 0, 2, 1, 1, 23, 1, 24));
    // count DEPTH-1 drops pushes, then pop to 5
    vecs.push_back(V(0, 2'b11, 40, 41, 0, 4, 1, 1, 23, 1, 24));
    vecs.push_back(V(0, 2'b11, 42, 43, 0, 6, 1, 1, 23, 1, 24));
    vecs.push_back(V(0, 2'b01, 44,  0, 0, 7, 0, 1, 23, 1, 24));
    vecs.push_back(V(0, 2'b11, 45, 46, 0, 7, 0, 1, 23, 1, 24));
    vecs.push_back(V(0, 2'b00,  0,  0, 2, 5, 1, 1, 40, 1, 41));
    // flush beats same-cycle push and pop
    vecs.push_back(V(1, 2'b11, 30, 31, 2, 0, 1, 0,  0, 0,  0));
    vecs.push_back(V(0, 2'b11, 32, 33, 0, 2, 1, 1, 32, 1, 33));
    vecs.push_back(V(0, 2'b11, 34, 35, 0, 4, 1, 1, 32, 1, 33));

    rst = 1'b1;
    drive(0, 2'b00, 0, 0, 0);
    #12;
    check("reset_state", 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 0, 1, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].flush, vecs[k].iv, vecs[k].i0, vecs[k].i1, vecs[k].ack);
      @(posedge clk); #1;
      check($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].rdy,
            vecs[k].v0, vecs[k].e0, vecs[k].v1, vecs[k].e1);
    end

    // async reset between edges at count 4: outputs clear before the next edge
    drive(0, 2'b00, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_midcycle", 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 2'b11, 50, 51, 0);
    @(posedge clk); #1;
    check("push_after_async_reset", 2, 1, 1, 50, 1, 51);
    drive(0, 2'b00, 0, 0, 2);
    @(posedge clk); #1;
    check("drain_after_async_reset", 0, 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
